// File: rtl/exe_div_pkg.sv
// exe_div_pkg: shared definitions for the EXE-stage multi-cycle divider.
//   div_state_e    : divider FSM states
//   DIV_CYCLES     : number of radix-2 iterations (one quotient bit each)
//   DIV_ZERO_QUOT  : quotient returned for a zero divisor
package exe_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ZERO = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    localparam int unsigned DIV_CYCLES    = 32;
    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/exe_div_if.sv
// exe_div_if: pipeline <-> divider signal bundle.
//   start_i/signed_i/cancel_i : request, signedness, flush (pipeline -> divider)
//   op1_i/op2_i               : forwarded dividend / divisor
//   stall_o/ready_o           : freeze request / result valid (divider -> pipeline)
//   hi_o/lo_o                 : remainder / quotient
// master = pipeline side, slave = divider side.
interface exe_div_if;
    logic        start_i;
    logic        signed_i;
    logic        cancel_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic        stall_o;
    logic        ready_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output start_i, signed_i, cancel_i, op1_i, op2_i,
        input  stall_o, ready_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, signed_i, cancel_i, op1_i, op2_i,
        output stall_o, ready_o, hi_o, lo_o
    );
endinterface

// File: rtl/exe_div_step.sv
// div_step: one combinational radix-2 restoring division iteration.
//   i_rem  : 33-bit partial remainder
//   i_bit  : next dividend bit (MSB first)
//   i_div  : divisor magnitude
//   o_rem  : updated partial remainder
//   o_qbit : quotient bit produced by this iteration
module div_step (
    input  logic [32:0] i_rem,
    input  logic        i_bit,
    input  logic [31:0] i_div,
    output logic [32:0] o_rem,
    output logic        o_qbit
);
    logic [32:0] w_shift;
    logic [32:0] w_diff;

    // The partial remainder is always below the divisor, so its upper bit
    // is zero and the shift cannot overflow 33 bits.
    assign w_shift = {i_rem[31:0], i_bit};
    assign w_diff  = w_shift - {1'b0, i_div};
    assign o_qbit  = ~w_diff[32];
    assign o_rem   = w_diff[32] ? w_shift : w_diff;
endmodule

// File: rtl/exe_div.sv
// exe_div: multi-cycle 32-bit MIPS DIV/DIVU for the EXE stage.
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : exe_div_if.slave (start/signed/cancel/operands in,
//             stall/ready/hi=remainder/lo=quotient out)
// Build option EXE_DIV_ZERO_FAST_EN: a zero divisor short-cuts through the
// ZERO state (2-cycle latency); otherwise it runs the full iteration sequence
// and the result is forced at load time.
module exe_div
    import exe_div_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_n_i,
    exe_div_if.slave bus
);
    div_state_e  r_state;
    div_state_e  w_state_nxt;
    logic [5:0]  r_cnt;
    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_div;
    logic [31:0] r_op1;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_qneg;
    logic        r_rneg;

    logic        w_start_ok;
    logic        w_last;
    logic        w_op1_neg;
    logic        w_op2_neg;
    logic [31:0] w_op1_abs;
    logic [31:0] w_op2_abs;
    logic [32:0] w_rem_nxt;
    logic        w_qbit;
    logic [31:0] w_quo_fin;
    logic [31:0] w_lo_fix;
    logic [31:0] w_hi_fix;
    logic [31:0] w_lo_load;
    logic [31:0] w_hi_load;

    assign w_start_ok = bus.start_i & ~bus.cancel_i;
    assign w_last     = (r_cnt == 6'(DIV_CYCLES - 1));
    assign w_op1_neg  = bus.signed_i & bus.op1_i[31];
    assign w_op2_neg  = bus.signed_i & bus.op2_i[31];
    assign w_op1_abs  = w_op1_neg ? -bus.op1_i : bus.op1_i;
    assign w_op2_abs  = w_op2_neg ? -bus.op2_i : bus.op2_i;

    div_step u_step (
        .i_rem  (r_rem),
        .i_bit  (r_quo[31]),
        .i_div  (r_div),
        .o_rem  (w_rem_nxt),
        .o_qbit (w_qbit)
    );

    // The dividend register shifts out MSB-first while quotient bits shift in,
    // so on the last iteration the final quotient is taken straight from the
    // step output rather than from the register.
    assign w_quo_fin = {r_quo[30:0], w_qbit};
    assign w_lo_fix  = r_qneg ? -w_quo_fin : w_quo_fin;
    assign w_hi_fix  = r_rneg ? -w_rem_nxt[31:0] : w_rem_nxt[31:0];

`ifdef EXE_DIV_ZERO_FAST_EN
    assign w_lo_load = w_lo_fix;
    assign w_hi_load = w_hi_fix;
`else
    logic r_zero;
    assign w_lo_load = r_zero ? DIV_ZERO_QUOT : w_lo_fix;
    assign w_hi_load = r_zero ? r_op1 : w_hi_fix;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.cancel_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_i) begin
`ifdef EXE_DIV_ZERO_FAST_EN
                        w_state_nxt = (bus.op2_i == '0) ? ST_ZERO : ST_BUSY;
`else
                        w_state_nxt = ST_BUSY;
`endif
                    end
                end
                ST_BUSY: if (w_last) w_state_nxt = ST_DONE;
                ST_ZERO: w_state_nxt = ST_DONE;
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_op1  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
`ifndef EXE_DIV_ZERO_FAST_EN
            r_zero <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_op1  <= bus.op1_i;
                        r_cnt  <= '0;
                        r_rem  <= '0;
                        r_quo  <= w_op1_abs;
                        r_div  <= w_op2_abs;
                        r_qneg <= w_op1_neg ^ w_op2_neg;
                        r_rneg <= w_op1_neg;
`ifndef EXE_DIV_ZERO_FAST_EN
                        r_zero <= (bus.op2_i == '0);
`endif
                    end
                end
                ST_BUSY: begin
                    if (!bus.cancel_i) begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_fin;
                        r_cnt <= r_cnt + 6'd1;
                        if (w_last) begin
                            r_hi <= w_hi_load;
                            r_lo <= w_lo_load;
                        end
                    end
                end
                ST_ZERO: begin
                    if (!bus.cancel_i) begin
                        r_hi <= r_op1;
                        r_lo <= DIV_ZERO_QUOT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready_o = (r_state == ST_DONE);
    assign bus.stall_o = bus.start_i & ~bus.ready_o & ~bus.cancel_i;
    assign bus.hi_o    = r_hi;
    assign bus.lo_o    = r_lo;
endmodule

// File: tb/tb_exe_div.sv
// tb_exe_div: directed self-checking bench for exe_div.
module tb_exe_div;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    exe_div_if bus ();

    exe_div dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

`ifdef EXE_DIV_ZERO_FAST_EN
    localparam int ZERO_CYC = 2;
`else
    localparam int ZERO_CYC = 33;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Starts a divide at the next cycle (cycle 0), waits for ready_o and checks
    // latency, stall behaviour and results. start_i is left high on return.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int cyc;
        bit got;
        bit stall_ok;
        @(posedge clk); #1;
        bus.start_i  = 1'b1;
        bus.signed_i = sgn;
        bus.op1_i    = a;
        bus.op2_i    = b;
        cyc = 0; got = 0; stall_ok = 1;
        while (!got && cyc < 60) begin
            @(negedge clk);
            if (bus.ready_o) got = 1;
            else if (!bus.stall_o) stall_ok = 0;
            if (!got) begin
                @(posedge clk); #1;
                cyc++;
                if (cyc == 4) begin
                    // operands are only sampled in IDLE; scramble them while busy
                    bus.op1_i    = ~a;
                    bus.op2_i    = 32'h0000_0005;
                    bus.signed_i = ~sgn;
                end
            end
        end
        check_eq({tag, "_cycle"}, cyc, exp_cyc);
        check_eq({tag, "_lo"}, bus.lo_o, exp_lo);
        check_eq({tag, "_hi"}, bus.hi_o, exp_hi);
        check_eq({tag, "_stall_busy"}, 32'(stall_ok), 32'd1);
        check_eq({tag, "_stall_done"}, 32'(bus.stall_o), 32'd0);
    endtask

    // Drops start in the cycle after DONE and confirms ready_o lasted one cycle.
    task automatic go_idle(input string tag);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        @(negedge clk);
        check_eq({tag, "_ready_one"}, 32'(bus.ready_o), 32'd0);
        check_eq({tag, "_stall_idle"}, 32'(bus.stall_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_ready;
        n_checks = 0;
        n_fail   = 0;
        rst_n        = 1'b0;
        bus.start_i  = 1'b0;
        bus.signed_i = 1'b0;
        bus.cancel_i = 1'b0;
        bus.op1_i    = '0;
        bus.op2_i    = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(bus.ready_o), 32'd0);
        check_eq("rst_stall", 32'(bus.stall_o), 32'd0);
        check_eq("rst_hi", bus.hi_o, 32'd0);
        check_eq("rst_lo", bus.lo_o, 32'd0);
        rst_n = 1'b1;

        do_div("divu_7_2", 1'b0, 32'd7, 32'd2, 33, 32'd3, 32'd1);
        go_idle("divu_7_2");
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        do_div("divu_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 33, 32'h7FFF_FFFC, 32'd1);
        do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);
        do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF, 32'd0);
        do_div("div_zero_s", 1'b1, 32'h1234_5678, 32'd0, ZERO_CYC, 32'hFFFF_FFFF, 32'h1234_5678);
        do_div("div_zero_u", 1'b0, 32'h1234_5678, 32'd0, ZERO_CYC, 32'hFFFF_FFFF, 32'h1234_5678);
        go_idle("div_zero_u");

        // cancel in cycle 10 of 100/7
        @(posedge clk); #1;
        bus.start_i = 1'b1; bus.signed_i = 1'b0;
        bus.op1_i = 32'd100; bus.op2_i = 32'd7;
        repeat (10) begin @(posedge clk); #1; end
        bus.cancel_i = 1'b1;
        @(negedge clk);
        check_eq("cancel_stall", 32'(bus.stall_o), 32'd0);
        @(posedge clk); #1;
        bus.cancel_i = 1'b0;
        bus.start_i  = 1'b0;
        saw_ready = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.ready_o) saw_ready = 1;
        end
        check_eq("cancel_no_ready", 32'(saw_ready), 32'd0);
        check_eq("cancel_hi_kept", bus.hi_o, 32'h1234_5678);
        check_eq("cancel_lo_kept", bus.lo_o, 32'hFFFF_FFFF);
        do_div("restart_100_7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2);
        go_idle("restart_100_7");

        // reset in cycle 15 of a divide
        @(posedge clk); #1;
        bus.start_i = 1'b1; bus.signed_i = 1'b1;
        bus.op1_i = 32'd1000; bus.op2_i = 32'd3;
        repeat (15) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        #1;
        check_eq("rstmid_ready", 32'(bus.ready_o), 32'd0);
        check_eq("rstmid_stall", 32'(bus.stall_o), 32'd0);
        check_eq("rstmid_hi", bus.hi_o, 32'd0);
        check_eq("rstmid_lo", bus.lo_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // back-to-back: second start sampled the cycle after DONE (ready at 33 and 67)
        do_div("b2b_9_3", 1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0);
        do_div("b2b_10_4", 1'b0, 32'd10, 32'd4, 33, 32'd2, 32'd2);
        go_idle("b2b_10_4");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/exe_div.md
# exe_div

Multi-cycle 32-bit integer divider for MIPS DIV/DIVU in the EXE stage. It consumes the forwarded operands produced by the EXE operand-forwarding logic and returns quotient in LO and remainder in HI. While the operation runs it holds the pipeline with a stall request. Cancel is used on an exception or flush.

## Interface
Parameters:
- none; widths are fixed at 32 bits.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  a DIV/DIVU occupies EXE; held high by the pipeline while stalled.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- cancel_i  in  1  flush; aborts any operation.
- op1_i  in  32  dividend (forwarded rs).
- op2_i  in  32  divisor (forwarded rt).
- stall_o  out  1  request to freeze IF..EXE.
- ready_o  out  1  hi_o/lo_o valid for the instruction in EXE this cycle.
- hi_o  out  32  remainder.
- lo_o  out  32  quotient.

## Operation
- States: IDLE, BUSY, ZERO, DONE.
- IDLE, start_i=1, cancel_i=0, op2_i≠0:
  - Capture |op1|, |op2| (absolute values only when signed_i=1).
  - Capture quotient sign (op1[31]^op2[31]) and remainder sign (op1[31]), both only when signed_i=1.
  - Clear iteration counter; go to BUSY.
- IDLE, start_i=1, cancel_i=0, op2_i=0: go to ZERO.
- BUSY performs radix-2 restoring division, one quotient bit per cycle, MSB first.
  - Partial remainder is 33 bits wide: shift left, trial-subtract divisor, keep the result if it is non-negative.
  - After the 32nd iteration: apply the sign correction (negate quotient and/or remainder per the captured signs), load hi_o/lo_o, go to DONE.
- ZERO: load hi_o=op1 as captured, lo_o=32'hFFFFFFFF, regardless of signed_i; go to DONE.
- DONE: ready_o=1 for exactly one cycle; next state is IDLE unconditionally.
  - If start_i is still high in IDLE, that is a new back-to-back divide and it restarts.
- stall_o = start_i & ~ready_o & ~cancel_i.
- hi_o/lo_o hold their value until the next DONE load; they are not cleared on IDLE.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. The algorithm yields this naturally; no special case.
- cancel_i=1 in any state forces IDLE next cycle. Results are not updated and ready_o is not asserted. cancel_i has priority over start_i.

## Timing
- Reset values: state=IDLE, counter=0; stall_o=0 when start_i=0; ready_o=0, hi_o=0, lo_o=0.
- Normal divide: start_i is sampled in cycle 0, BUSY covers cycles 1..32, DONE/ready_o is in cycle 33.
  - stall_o is high in cycles 0..32 and low in cycle 33.
- Divide by zero: ZERO in cycle 1, ready_o in cycle 2 (EXE_DIV_ZERO_FAST_EN defined). Without the macro, see Configuration.
- Back-to-back divides: the second start is sampled in the cycle after DONE; there are no dead cycles beyond IDLE.
- Reset asserted mid-operation: immediate return to IDLE with all reset values.
- op1_i/op2_i/signed_i are only sampled in IDLE; changes during BUSY are ignored.

## Configuration
- EXE_DIV_ZERO_FAST_EN defined: a zero divisor takes the ZERO path, with a 2-cycle latency.
- EXE_DIV_ZERO_FAST_EN undefined: the ZERO state is removed.
  - A zero divisor runs the full BUSY sequence with the same 33-cycle latency as any divide.
  - The result is still forced to hi=op1, lo=32'hFFFFFFFF at DONE load, so results are identical in both builds.

## Structure
- Shared package holds:
  - the state enum (IDLE, BUSY, ZERO, DONE);
  - DIV_CYCLES=32;
  - the divide-by-zero quotient constant 32'hFFFFFFFF.
- One sub-module, div_step: combinational single iteration.
  - Inputs: 33-bit partial remainder, next dividend bit, divisor.
  - Outputs: new partial remainder, quotient bit.
- The FSM, counter and sign fix stay in exe_div.

## Test plan
- DIVU 7/2 → ready_o in cycle 33, lo=3, hi=1; stall_o high for cycles 0..32.
- DIV 0xFFFFFFF9 (-7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with the same operands → lo=0x7FFFFFFC, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. DIVU 0xFFFFFFFF / 1 → lo=0xFFFFFFFF, hi=0.
- Divide 0x12345678 / 0, both signed_i values:
  - Result hi=0x12345678, lo=0xFFFFFFFF.
  - ready_o in cycle 2 with the macro, cycle 33 without.
- Cancel, then restart:
  - Start 100/7, cancel_i in cycle 10 → IDLE in cycle 11, no ready_o, hi/lo keep previous values.
  - Then start 100/7 → lo=14, hi=2 after 33 cycles.
- Reset mid-operation and back-to-back:
  - Assert rst_n_i=0 in cycle 15 → all outputs 0 immediately.
  - After release, two back-to-back divides (9/3 then 10/4) → ready_o in cycles 33 and 67, results lo=3/hi=0 then lo=2/hi=2.
